// File: rtl/axis_frame_monitor.sv
// axis_frame_monitor
// Sink-side AXI4-Stream video frame checker. It accepts beats under a
// programmable tready mask. It checks the frame, line and beat structure
// against the configured geometry. It keeps sticky error flags and
// saturating frame and error counters, and it reports the XOR checksum
// of each completed frame.
module axis_frame_monitor #(
    parameter int unsigned T_DATA_WIDTH = 64,
    parameter int unsigned T_USER_WIDTH = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned BP_WIDTH     = 8
) (
    input  logic                    aclk,
    input  logic                    aclk_reset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [T_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [T_USER_WIDTH-1:0] s_axis_tuser,
    input  logic                    cfg_enable,
    input  logic [CNT_WIDTH-1:0]    cfg_line_beats,
    input  logic [CNT_WIDTH-1:0]    cfg_lines,
    input  logic [BP_WIDTH-1:0]     cfg_bp_pattern,
    input  logic                    cfg_clear,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic [CNT_WIDTH-1:0]    error_count,
    output logic [4:0]              err_flags,
    output logic [T_DATA_WIDTH-1:0] frame_checksum,
    output logic                    irq_frame_done,
    output logic                    busy
);

    localparam int unsigned BP_IDX_W = (BP_WIDTH > 1) ? $clog2(BP_WIDTH) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Saturating increment for the per-line and per-frame position counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a);
        return (a == '1) ? a : a + CNT_WIDTH'(1);
    endfunction

    // Saturating add of a small amount. Up to two frames can close on one
    // edge: a mid-frame SOF that is also a single-beat EOF.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [1:0]           n);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, n};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Registered state
    logic [BP_IDX_W-1:0]     bp_idx_q, bp_idx_d;
    logic                    tready_q;
    logic [0:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]    line_cnt_q, line_cnt_d;
    logic                    frame_err_q, frame_err_d;
    logic [T_DATA_WIDTH-1:0] csum_q, csum_d;
    logic [T_DATA_WIDTH-1:0] frame_csum_q, frame_csum_d;
    logic [CNT_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [4:0]              err_flags_q, err_flags_d;
    logic                    irq_q, irq_d;

    // Per-beat working values
    logic                    accept;
    logic                    sof;
    logic                    eof;
    logic [CNT_WIDTH-1:0]    beats_w;
    logic [CNT_WIDTH-1:0]    lines_w;
    logic [CNT_WIDTH-1:0]    lines_incl;
    logic                    ferr_w;
    logic [T_DATA_WIDTH-1:0] run_csum;
    logic [1:0]              n_end;
    logic [1:0]              n_bad;

    // Only tuser[1:0] carry meaning; the rest of the bus is intentionally ignored.
    logic                    tuser_unused;
    assign tuser_unused = ^s_axis_tuser;

    assign accept = s_axis_tvalid & tready_q;
    assign sof    = s_axis_tuser[0];
    assign eof    = s_axis_tuser[1];

    // Backpressure phase: walks the pattern while enabled, parked at phase 0 otherwise
    always_comb begin
        bp_idx_d = bp_idx_q;
        if (!cfg_enable) begin
            bp_idx_d = '0;
        end else if (bp_idx_q == BP_IDX_W'(BP_WIDTH - 1)) begin
            bp_idx_d = '0;
        end else begin
            bp_idx_d = bp_idx_q + BP_IDX_W'(1);
        end
    end

    // Backpressure phase register and registered tready
    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            bp_idx_q <= '0;
            tready_q <= 1'b0;
        end else begin
            bp_idx_q <= bp_idx_d;
            tready_q <= cfg_enable & cfg_bp_pattern[bp_idx_q];
        end
    end

    // Frame tracking: structure checks, checksum, counters and flags for one accepted beat
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_err_d  = frame_err_q;
        csum_d       = csum_q;
        frame_csum_d = frame_csum_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_flags_d  = err_flags_q;
        irq_d        = 1'b0;
        beats_w      = '0;
        lines_w      = '0;
        lines_incl   = '0;
        ferr_w       = 1'b0;
        run_csum     = '0;
        n_end        = '0;
        n_bad        = '0;

        if (accept) begin
            if ((state_q == ST_IDLE) && !sof) begin
                // Stray beat outside any frame: flag it and drop it.
                err_flags_d[0] = 1'b1;
            end else begin
                if ((state_q == ST_ACTIVE) && !sof) begin
                    beats_w  = sat_inc(beat_cnt_q);
                    lines_w  = line_cnt_q;
                    ferr_w   = frame_err_q;
                    run_csum = csum_q ^ s_axis_tdata;
                end else begin
                    if (state_q == ST_ACTIVE) begin
                        // SOF inside a frame: close the old frame as errored.
                        err_flags_d[4] = 1'b1;
                        frame_csum_d   = csum_q;
                        n_end          = 2'd1;
                        n_bad          = 2'd1;
                    end
                    // This beat is the first beat of a new frame.
                    beats_w  = CNT_WIDTH'(1);
                    lines_w  = '0;
                    ferr_w   = 1'b0;
                    run_csum = s_axis_tdata;
                end

                lines_incl = sat_inc(lines_w);

                if (s_axis_tlast) begin
                    if (beats_w != cfg_line_beats) begin
                        err_flags_d[1] = 1'b1;
                        ferr_w         = 1'b1;
                    end
                    beat_cnt_d = '0;
                    line_cnt_d = lines_incl;
                end else begin
                    beat_cnt_d = beats_w;
                    line_cnt_d = lines_w;
                end

                if (eof) begin
                    if (lines_incl != cfg_lines) begin
                        err_flags_d[2] = 1'b1;
                        ferr_w         = 1'b1;
                    end
                    if (!s_axis_tlast) begin
                        err_flags_d[3] = 1'b1;
                        ferr_w         = 1'b1;
                    end
                    frame_csum_d = run_csum;
                    n_end        = n_end + 2'd1;
                    n_bad        = n_bad + {1'b0, ferr_w};
                    state_d      = ST_IDLE;
                    beat_cnt_d   = '0;
                    line_cnt_d   = '0;
                    frame_err_d  = 1'b0;
                    csum_d       = run_csum;
                end else begin
                    state_d     = ST_ACTIVE;
                    frame_err_d = ferr_w;
                    csum_d      = run_csum;
                end
            end
        end

        if (n_end != 2'd0) begin
            irq_d = 1'b1;
        end
        frame_cnt_d = sat_add(frame_cnt_q, n_end);
        err_cnt_d   = sat_add(err_cnt_q, n_bad);

        // A clear on the same edge as an increment leaves the counters at zero.
        if (cfg_clear) begin
            err_flags_d = '0;
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end
    end

    // Frame tracking state registers
    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            line_cnt_q   <= '0;
            frame_err_q  <= 1'b0;
            csum_q       <= '0;
            frame_csum_q <= '0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            err_flags_q  <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            line_cnt_q   <= line_cnt_d;
            frame_err_q  <= frame_err_d;
            csum_q       <= csum_d;
            frame_csum_q <= frame_csum_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_flags_q  <= err_flags_d;
            irq_q        <= irq_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign frame_count    = frame_cnt_q;
    assign error_count    = err_cnt_q;
    assign err_flags      = err_flags_q;
    assign frame_checksum = frame_csum_q;
    assign irq_frame_done = irq_q;
    assign busy           = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_axis_frame_monitor.sv
// tb_axis_frame_monitor
// Directed bench for axis_frame_monitor. It runs a table of whole-frame
// vectors, then hand-written sequences for the backpressure phase,
// stray and mid-frame SOF, EOF without tlast, enable pause, clear
// collision, saturation and reset.
module tb_axis_frame_monitor;

    localparam int unsigned DW = 64;
    localparam int unsigned UW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = 8;

    logic          aclk;
    logic          aclk_reset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic          cfg_enable;
    logic [CW-1:0] cfg_line_beats;
    logic [CW-1:0] cfg_lines;
    logic [BW-1:0] cfg_bp_pattern;
    logic          cfg_clear;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] error_count;
    logic [4:0]    err_flags;
    logic [DW-1:0] frame_checksum;
    logic          irq_frame_done;
    logic          busy;

    axis_frame_monitor #(
        .T_DATA_WIDTH (DW),
        .T_USER_WIDTH (UW),
        .CNT_WIDTH    (CW),
        .BP_WIDTH     (BW)
    ) dut (
        .aclk           (aclk),
        .aclk_reset     (aclk_reset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .cfg_enable     (cfg_enable),
        .cfg_line_beats (cfg_line_beats),
        .cfg_lines      (cfg_lines),
        .cfg_bp_pattern (cfg_bp_pattern),
        .cfg_clear      (cfg_clear),
        .frame_count    (frame_count),
        .error_count    (error_count),
        .err_flags      (err_flags),
        .frame_checksum (frame_checksum),
        .irq_frame_done (irq_frame_done),
        .busy           (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;

    always @(negedge aclk) begin
        if (irq_frame_done) irq_cnt = irq_cnt + 1;
    end

    typedef struct packed {
        logic [7:0]    pat;
        logic [3:0]    lb;
        logic [3:0]    ln;
        logic [3:0]    l0;
        logic [3:0]    l1;
        logic [3:0]    l2;
        logic [3:0]    l3;
        logic [4:0]    flags;
        logic [3:0]    errs;
        logic [63:0]   csum;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_pulse();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    // Present one beat and hold it until an edge with tready high accepts it.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic s, input logic e);
        logic acc;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = {2'b00, e, s};
        acc = 1'b0;
        for (int c = 0; c < 64 && !acc; c++) begin
            acc = s_axis_tready;
            tick();
        end
        if (!acc) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL beat_accept_timeout: got tready 0 expected 1 within 64 cycles");
        end
    endtask

    // Whole frame with sequential data starting at 'first'. A zero length ends the line list.
    task automatic send_lines(input logic [63:0] first, input logic [3:0] l0, input logic [3:0] l1,
                              input logic [3:0] l2, input logic [3:0] l3);
        logic [3:0]  lens [4];
        logic [63:0] d;
        int          nl;
        lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
        nl = 0;
        for (int i = 0; i < 4; i++) begin
            if (lens[i] != 4'd0 && nl == i) nl = i + 1;
        end
        d = first;
        for (int i = 0; i < nl; i++) begin
            for (int j = 0; j < int'(lens[i]); j++) begin
                send_beat(d, j == int'(lens[i]) - 1, d == first,
                          (j == int'(lens[i]) - 1) && (i == nl - 1));
                d = d + 64'd1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int          irq0;
        logic [7:0]  p;
        string       nm;

        vecs[0] = '{pat:8'hFF, lb:4, ln:3, l0:4, l1:4, l2:4, l3:0, flags:5'b00000, errs:0, csum:64'h0C};
        vecs[1] = '{pat:8'hFF, lb:4, ln:3, l0:4, l1:5, l2:4, l3:0, flags:5'b00010, errs:1, csum:64'h01};
        vecs[2] = '{pat:8'h55, lb:4, ln:3, l0:4, l1:4, l2:4, l3:0, flags:5'b00000, errs:0, csum:64'h0C};
        vecs[3] = '{pat:8'hFF, lb:4, ln:3, l0:4, l1:4, l2:0, l3:0, flags:5'b00100, errs:1, csum:64'h08};
        vecs[4] = '{pat:8'hFF, lb:0, ln:3, l0:4, l1:4, l2:4, l3:0, flags:5'b00010, errs:1, csum:64'h0C};
        vecs[5] = '{pat:8'hFF, lb:4, ln:0, l0:4, l1:4, l2:4, l3:0, flags:5'b00100, errs:1, csum:64'h0C};
        vecs[6] = '{pat:8'hFF, lb:1, ln:1, l0:1, l1:0, l2:0, l3:0, flags:5'b00000, errs:0, csum:64'h01};
        vecs[7] = '{pat:8'h81, lb:2, ln:4, l0:2, l1:2, l2:2, l3:2, flags:5'b00000, errs:0, csum:64'h08};
        vecs[8] = '{pat:8'h55, lb:3, ln:2, l0:3, l1:3, l2:0, l3:0, flags:5'b00000, errs:0, csum:64'h07};
        vecs[9] = '{pat:8'hFF, lb:2, ln:2, l0:3, l1:2, l2:0, l3:0, flags:5'b00010, errs:1, csum:64'h01};

        aclk_reset     = 1'b1;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tlast   = 1'b0;
        s_axis_tuser   = '0;
        cfg_enable     = 1'b1;
        cfg_line_beats = 4'd4;
        cfg_lines      = 4'd3;
        cfg_bp_pattern = 8'hFF;
        cfg_clear      = 1'b0;

        // Reset state while reset is still asserted
        tick(); tick(); tick();
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_err_flags", 64'(err_flags), 64'd0);
        check("rst_checksum", frame_checksum, 64'd0);
        check("rst_irq", 64'(irq_frame_done), 64'd0);
        aclk_reset = 1'b0;
        tick();

        // tready follows the pattern phase by phase, starting at phase 0 after enable
        cfg_enable = 1'b0;
        tick(); tick();
        check("dis_tready", 64'(s_axis_tready), 64'd0);
        p = 8'h35;
        cfg_bp_pattern = p;
        cfg_enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            nm = $sformatf("bp_phase_%0d", k);
            check(nm, 64'(s_axis_tready), 64'(p[k % 8]));
        end

        // Table of whole frames
        for (int v = 0; v < NV; v++) begin
            cfg_bp_pattern = vecs[v].pat;
            cfg_line_beats = vecs[v].lb;
            cfg_lines      = vecs[v].ln;
            clear_pulse();
            irq0 = irq_cnt;
            send_lines(64'd1, vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3);
            tick(); tick();
            check($sformatf("v%0d_frame_count", v), 64'(frame_count), 64'd1);
            check($sformatf("v%0d_error_count", v), 64'(error_count), 64'(vecs[v].errs));
            check($sformatf("v%0d_err_flags", v), 64'(err_flags), 64'(vecs[v].flags));
            check($sformatf("v%0d_checksum", v), frame_checksum, vecs[v].csum);
            check($sformatf("v%0d_irq_pulses", v), 64'(irq_cnt - irq0), 64'd1);
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
        end

        // Stray beats, then a SOF inside a frame
        cfg_bp_pattern = 8'hFF; cfg_line_beats = 4'd4; cfg_lines = 4'd3;
        clear_pulse();
        send_beat(64'h11, 1'b0, 1'b0, 1'b0);
        send_beat(64'h22, 1'b1, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        check("nosof_flags", 64'(err_flags), 64'h01);
        check("nosof_frame_count", 64'(frame_count), 64'd0);
        check("nosof_busy", 64'(busy), 64'd0);
        for (int i = 1; i <= 6; i++) send_beat(64'(i), i == 4, i == 1, 1'b0);
        send_beat(64'd7, 1'b0, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        check("midsof_irq", 64'(irq_frame_done), 64'd1);
        check("midsof_frame_count", 64'(frame_count), 64'd1);
        check("midsof_error_count", 64'(error_count), 64'd1);
        check("midsof_checksum", frame_checksum, 64'd7);
        check("midsof_flags", 64'(err_flags), 64'h11);
        check("midsof_busy", 64'(busy), 64'd1);
        tick();
        check("midsof_irq_one_cycle", 64'(irq_frame_done), 64'd0);
        for (int i = 8; i <= 18; i++) send_beat(64'(i), (i == 10) || (i == 14) || (i == 18), 1'b0, i == 18);
        s_axis_tvalid = 1'b0;
        tick();
        check("second_frame_count", 64'(frame_count), 64'd2);
        check("second_error_count", 64'(error_count), 64'd1);
        check("second_checksum", frame_checksum, 64'd20);
        check("second_flags", 64'(err_flags), 64'h11);

        // EOF without tlast
        cfg_lines = 4'd1;
        clear_pulse();
        send_beat(64'd1, 1'b0, 1'b1, 1'b0);
        send_beat(64'd2, 1'b0, 1'b0, 1'b0);
        send_beat(64'd4, 1'b0, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        tick();
        check("eofnl_flags", 64'(err_flags), 64'h08);
        check("eofnl_error_count", 64'(error_count), 64'd1);
        check("eofnl_frame_count", 64'(frame_count), 64'd1);
        check("eofnl_checksum", frame_checksum, 64'd7);
        check("eofnl_busy", 64'(busy), 64'd0);

        // Enable dropped mid-frame, then resumed
        cfg_lines = 4'd3;
        clear_pulse();
        for (int i = 1; i <= 6; i++) send_beat(64'(i), i == 4, i == 1, 1'b0);
        s_axis_tvalid = 1'b0;
        cfg_enable = 1'b0;
        tick(); tick(); tick();
        check("pause_tready", 64'(s_axis_tready), 64'd0);
        check("pause_busy", 64'(busy), 64'd1);
        check("pause_frame_count", 64'(frame_count), 64'd0);
        cfg_enable = 1'b1;
        for (int i = 7; i <= 12; i++) send_beat(64'(i), (i == 8) || (i == 12), 1'b0, i == 12);
        s_axis_tvalid = 1'b0;
        tick();
        check("resume_frame_count", 64'(frame_count), 64'd1);
        check("resume_error_count", 64'(error_count), 64'd0);
        check("resume_flags", 64'(err_flags), 64'd0);
        check("resume_checksum", frame_checksum, 64'h0C);

        // Clear on the same edge as a frame end (with errors) wins
        cfg_line_beats = 4'd3;
        clear_pulse();
        irq0 = irq_cnt;
        for (int i = 1; i <= 11; i++) send_beat(64'(i), (i == 4) || (i == 8), i == 1, 1'b0);
        cfg_clear = 1'b1;
        send_beat(64'd12, 1'b1, 1'b0, 1'b1);
        cfg_clear = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        check("clrwin_frame_count", 64'(frame_count), 64'd0);
        check("clrwin_error_count", 64'(error_count), 64'd0);
        check("clrwin_flags", 64'(err_flags), 64'd0);
        check("clrwin_checksum", frame_checksum, 64'h0C);
        check("clrwin_irq_pulses", 64'(irq_cnt - irq0), 64'd1);

        // Saturation: 17 errored single-beat frames on a 4-bit counter
        cfg_line_beats = 4'd1; cfg_lines = 4'd2;
        clear_pulse();
        for (int i = 0; i < 17; i++) send_beat(64'(100 + i), 1'b1, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        tick();
        check("sat_frame_count", 64'(frame_count), 64'd15);
        check("sat_error_count", 64'(error_count), 64'd15);
        check("sat_flags", 64'(err_flags), 64'h04);
        check("sat_checksum", frame_checksum, 64'd116);

        // Reset in the middle of a frame, then a full frame, then clear
        cfg_line_beats = 4'd4; cfg_lines = 4'd3;
        for (int i = 1; i <= 5; i++) send_beat(64'(i), i == 4, i == 1, 1'b0);
        s_axis_tvalid = 1'b0;
        irq0 = irq_cnt;
        aclk_reset = 1'b1;
        tick();
        check("mrst_tready", 64'(s_axis_tready), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_frame_count", 64'(frame_count), 64'd0);
        check("mrst_error_count", 64'(error_count), 64'd0);
        check("mrst_checksum", frame_checksum, 64'd0);
        aclk_reset = 1'b0;
        send_lines(64'd1, 4'd4, 4'd4, 4'd4, 4'd0);
        tick();
        check("post_rst_frame_count", 64'(frame_count), 64'd1);
        check("post_rst_error_count", 64'(error_count), 64'd0);
        check("post_rst_flags", 64'(err_flags), 64'd0);
        check("post_rst_checksum", frame_checksum, 64'h0C);
        check("post_rst_irq_pulses", 64'(irq_cnt - irq0), 64'd1);
        clear_pulse();
        check("final_clear_frame_count", 64'(frame_count), 64'd0);
        check("final_clear_error_count", 64'(error_count), 64'd0);
        check("final_clear_flags", 64'(err_flags), 64'd0);
        check("final_clear_checksum_kept", frame_checksum, 64'h0C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
